// File: rtl/pipeline_ctrl_pkg.sv
// Shared stall-vector constants, stall bit indices and controller FSM state type
// for the five-stage pipeline.
package pipeline_ctrl_pkg;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam int unsigned STALL_PC    = 0;
  localparam int unsigned STALL_IFID  = 1;
  localparam int unsigned STALL_IDEX  = 2;
  localparam int unsigned STALL_EXMEM = 3;
  localparam int unsigned STALL_MEMWB = 4;
  localparam int unsigned STALL_WB    = 5;

  typedef enum logic {
    CTRL_RUN,
    CTRL_FLUSH
  } ctrl_state_t;

  // The latest requesting stage wins: it freezes itself and everything upstream.
  function automatic logic [5:0] stall_encode(input logic id, input logic ex, input logic mem);
    logic [5:0] v;
    if (mem)     v = STALL_MEM;
    else if (ex) v = STALL_EX;
    else if (id) v = STALL_ID;
    else         v = STALL_NONE;
    return v;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Counts consecutive stalled cycles and raises a sticky timeout flag once the
// count reaches STALL_LIMIT.
module stall_watchdog
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_active_i,
  input  logic flush_i,
  output logic stall_timeout_o
);

  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  always_comb begin
    cnt_d = '0;
    if (stall_active_i && !flush_i) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 8'd1;
    end
    timeout_d = timeout_q | (cnt_d == LIMIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_timeout_o = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: merges stage stall requests, sequences the
// exception/ERET flush and hosts the stall watchdog.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned STALL_LIMIT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              excp_valid,
  input  logic              excp_eret,
  input  logic [ADDR_W-1:0] excp_vector,
  input  logic [ADDR_W-1:0] cp0_epc,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              stall_timeout
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  ctrl_state_t       state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] target;

  assign target = excp_eret ? cp0_epc : excp_vector;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    stall   = STALL_NONE;
    flush   = 1'b0;
    new_pc  = '0;
    unique case (state_q)
      CTRL_RUN: begin
        if (excp_valid) begin
          flush  = 1'b1;
          new_pc = target;
          pc_d   = target;
          if (FLUSH_CYCLES > 1) begin
            state_d = CTRL_FLUSH;
            cnt_d   = FLUSH_INIT;
          end
        end else begin
          stall = stall_encode(stallreq_id, stallreq_ex, stallreq_mem);
        end
      end
      CTRL_FLUSH: begin
        flush  = 1'b1;
        new_pc = pc_q;
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = CTRL_RUN;
      end
      default: state_d = CTRL_RUN;
    endcase
    // Outputs are combinational from the requests, so they must be forced
    // low explicitly while reset is held.
    if (!rst) begin
      stall  = STALL_NONE;
      flush  = 1'b0;
      new_pc = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CTRL_RUN;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  stall_watchdog #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_watchdog (
    .clk            (clk),
    .rst            (rst),
    .stall_active_i (|stall),
    .flush_i        (flush),
    .stall_timeout_o(stall_timeout)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: two instances (3-cycle and 1-cycle
// flush) driven in lockstep against a behavioural model, plus directed vectors.
module tb_pipeline_ctrl;

  localparam int LIM = 8;

  logic        clk;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        excp_valid, excp_eret;
  logic [31:0] excp_vector, cp0_epc;

  logic [5:0]  stall3, stall1;
  logic        flush3, flush1;
  logic [31:0] pc3, pc1;
  logic        to3, to1;

  pipeline_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(3), .STALL_LIMIT(LIM)) u_dut3 (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excp_valid(excp_valid), .excp_eret(excp_eret),
    .excp_vector(excp_vector), .cp0_epc(cp0_epc),
    .stall(stall3), .flush(flush3), .new_pc(pc3), .stall_timeout(to3)
  );

  pipeline_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(1), .STALL_LIMIT(LIM)) u_dut1 (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excp_valid(excp_valid), .excp_eret(excp_eret),
    .excp_vector(excp_vector), .cp0_epc(cp0_epc),
    .stall(stall1), .flush(flush1), .new_pc(pc1), .stall_timeout(to1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: flush cycles still owed, latched target, stall run length.
  int          fc   [2] = '{3, 1};
  int          rem  [2];
  logic [31:0] mpc  [2];
  int          scnt [2];
  bit          mto  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_exp(input int k, output logic [5:0] s, output logic f,
                                    output logic [31:0] p);
    s = 6'd0; f = 1'b0; p = 32'd0;
    if (!rst) return;
    if (rem[k] > 0) begin
      f = 1'b1; p = mpc[k];
    end else if (excp_valid) begin
      f = 1'b1; p = excp_eret ? cp0_epc : excp_vector;
    end else if (stallreq_mem) s = 6'b011111;
    else if (stallreq_ex)      s = 6'b001111;
    else if (stallreq_id)      s = 6'b000111;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; mpc[k] = 32'd0; scnt[k] = 0; mto[k] = 1'b0;
    end
  endtask

  task automatic model_update();
    logic [5:0] s; logic f; logic [31:0] p;
    if (!rst) return;
    for (int k = 0; k < 2; k++) begin
      model_exp(k, s, f, p);
      if (s != 6'd0 && !f) scnt[k] = (scnt[k] + 1 > LIM) ? LIM : scnt[k] + 1;
      else                 scnt[k] = 0;
      if (scnt[k] == LIM) mto[k] = 1'b1;
      if (rem[k] > 0) rem[k] = rem[k] - 1;
      else if (excp_valid) begin
        mpc[k] = p;
        rem[k] = fc[k] - 1;
      end
    end
  endtask

  // Inputs are applied just after a rising edge; outputs are checked mid-cycle.
  task automatic settle();
    logic [5:0] s; logic f; logic [31:0] p;
    if (!rst) model_reset();
    #3;
    model_exp(0, s, f, p);
    chk("m3_stall", {26'd0, stall3}, {26'd0, s});
    chk("m3_flush", {31'd0, flush3}, {31'd0, f});
    chk("m3_newpc", pc3, p);
    chk("m3_timeout", {31'd0, to3}, {31'd0, mto[0]});
    model_exp(1, s, f, p);
    chk("m1_stall", {26'd0, stall1}, {26'd0, s});
    chk("m1_flush", {31'd0, flush1}, {31'd0, f});
    chk("m1_newpc", pc1, p);
    chk("m1_timeout", {31'd0, to1}, {31'd0, mto[1]});
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic r, input logic id, input logic ex, input logic mem,
                       input logic ev, input logic er, input logic [31:0] vec,
                       input logic [31:0] epc);
    rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    excp_valid = ev; excp_eret = er; excp_vector = vec; cp0_epc = epc;
  endtask

  typedef struct {
    logic        r, id, ex, mem, ev, er;
    logic [31:0] vec, epc;
    logic [5:0]  s;
    logic        f;
    logic [31:0] p;
  } vec_t;

  vec_t tv [12];

  initial begin
    // Expected values for the FLUSH_CYCLES=3 instance.
    tv[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11111111, 32'h22222222, 6'b000000, 1'b0, 32'h0};
    tv[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 6'b001111, 1'b0, 32'h0};
    tv[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 6'b011111, 1'b0, 32'h0};
    tv[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 6'b000000, 1'b0, 32'h0};
    tv[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 6'b000111, 1'b0, 32'h0};
    tv[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hBFC00380, 32'h80001234, 6'b000000, 1'b1, 32'hBFC00380};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0BADF00D, 32'h0BADF00D, 6'b000000, 1'b1, 32'hBFC00380};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0BADF00D, 32'h80001234, 6'b000000, 1'b1, 32'hBFC00380};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0BADF00D, 32'h80001234, 6'b000000, 1'b1, 32'h80001234};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0BADF00D, 32'h0BADF00D, 6'b000000, 1'b1, 32'h80001234};
    tv[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0BADF00D, 32'h0BADF00D, 6'b000000, 1'b1, 32'h80001234};
    tv[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0BADF00D, 32'h0BADF00D, 6'b001111, 1'b0, 32'h0};

    model_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tv[i].r, tv[i].id, tv[i].ex, tv[i].mem, tv[i].ev, tv[i].er, tv[i].vec, tv[i].epc);
      settle();
      chk($sformatf("tv%0d_stall", i), {26'd0, stall3}, {26'd0, tv[i].s});
      chk($sformatf("tv%0d_flush", i), {31'd0, flush3}, {31'd0, tv[i].f});
      chk($sformatf("tv%0d_newpc", i), pc3, tv[i].p);
      chk($sformatf("tv%0d_timeout", i), {31'd0, to3}, 32'd0);
      advance();
    end

    // ERET with a single-cycle flush: redirect now, new_pc back to 0 next cycle.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12345678, 32'h80001234);
    settle();
    chk("eret_flush", {31'd0, flush1}, 32'd1);
    chk("eret_newpc", pc1, 32'h80001234);
    advance();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678, 32'h80001234);
    settle();
    chk("eret_after_flush", {31'd0, flush1}, 32'd0);
    chk("eret_after_newpc", pc1, 32'd0);
    advance();
    settle();
    advance();
    settle();
    advance();

    // Watchdog: timeout appears only after LIM consecutive stalled cycles.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    settle(); advance();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < LIM - 1; i++) begin
      settle(); advance();
    end
    settle();
    chk("wd_before_limit", {31'd0, to3}, 32'd0);
    advance();
    settle();
    chk("wd_at_limit3", {31'd0, to3}, 32'd1);
    chk("wd_at_limit1", {31'd0, to1}, 32'd1);
    chk("wd_no_stall_change", {26'd0, stall3}, 32'h0000000F);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      advance(); settle();
    end
    chk("wd_sticky", {31'd0, to3}, 32'd1);
    rst = 1'b0;
    settle();
    chk("wd_reset_clears", {31'd0, to3}, 32'd0);
    advance();

    // Watchdog: an idle cycle restarts the count.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 11; i++) begin
      stallreq_ex = (i != 5);
      settle(); advance();
    end
    settle();
    chk("wd_clear3", {31'd0, to3}, 32'd0);
    chk("wd_clear1", {31'd0, to1}, 32'd0);
    advance();

    // Reset in the middle of a 3-cycle flush aborts it.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hBFC00380, 32'd0);
    settle(); advance();
    excp_valid = 1'b0;
    settle();
    chk("midflush_active", {31'd0, flush3}, 32'd1);
    rst = 1'b0;
    settle();
    chk("midflush_rst_flush", {31'd0, flush3}, 32'd0);
    chk("midflush_rst_pc", pc3, 32'd0);
    advance();
    rst = 1'b1;
    settle();
    chk("after_rst_run", {31'd0, flush3}, 32'd0);
    advance();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(99) != 0), ($urandom_range(3) == 0), ($urandom_range(2) == 0),
            ($urandom_range(2) == 0), ($urandom_range(9) == 0), $urandom_range(1) == 1,
            $urandom, $urandom);
      settle();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
